// File: rtl/regfile_pkg.sv
// regfile_pkg: default geometry and ABI register indices for the register file.
package regfile_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int REG_ZERO   = 0;
   localparam int REG_SP     = 29;
   localparam int REG_RA     = 31;
endpackage

// File: rtl/multiport_register_file_if.sv
// multiport_register_file_if: read, write and issue ports of the register file.
interface multiport_register_file_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic [ADDR_W:0]          busy_cnt;
   modport master (output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
                   input rd_data, rd_busy, busy_cnt);
   modport slave (input rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
                  output rd_data, rd_busy, busy_cnt);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight writes plus a running busy count.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_en,
   input  logic [ADDR_W-1:0]    iss_addr,
   input  logic [2**ADDR_W-1:0] clr,
   output logic [2**ADDR_W-1:0] busy,
   output logic [ADDR_W:0]      busy_cnt
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int CW = ADDR_W + 1;
   logic set;
   logic [DEPTH-1:0] set_v;
   logic [CW-1:0] dec;
   // An issue beats a same-cycle clear: the issued instruction is the newer producer.
   always_comb begin
      set = iss_en && !(ZERO_REG != 0 && iss_addr == ADDR_W'(REG_ZERO));
      set_v = set ? (DEPTH'(1) << iss_addr) : '0;
      dec = '0;
      for (int r = 0; r < DEPTH; r++) dec = dec + CW'(busy[r] & clr[r] & ~set_v[r]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         busy_cnt <= '0;
      end else begin
         busy <= set_v | (busy & ~clr);
         busy_cnt <= busy_cnt + CW'(set && !busy[iss_addr]) - dec;
      end
   end
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: parametrised N-read/M-write register file with bypass,
// hardwired zero register and RAW-hazard busy scoreboard.
module multiport_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic clk,
   input logic rst,
   multiport_register_file_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int WI = NUM_WR > 1 ? $clog2(NUM_WR) : 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0] clr;
   logic [DEPTH-1:0] busy;
   function automatic logic [NUM_WR-1:0] hits(input logic [NUM_WR-1:0] en,
                                              input logic [NUM_WR*ADDR_W-1:0] addrs,
                                              input logic [ADDR_W-1:0] a);
      hits = '0;
      for (int w = 0; w < NUM_WR; w++) hits[w] = en[w] && addrs[w*ADDR_W +: ADDR_W] == a;
   endfunction
   // Highest-indexed hit wins; shared by write arbitration and read bypass.
   function automatic logic [WI-1:0] pick(input logic [NUM_WR-1:0] h);
      pick = '0;
      for (int w = 0; w < NUM_WR; w++) if (h[w]) pick = WI'(w);
   endfunction
   genvar r, p;
   generate
      for (r = 0; r < DEPTH; r++) begin : g_clr
         assign clr[r] = |hits(bus.wr_en, bus.wr_addr, ADDR_W'(r));
      end
   endgenerate
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++)
         if (rst) mem[i] <= '0;
         else if (clr[i] && !(ZERO_REG != 0 && i == REG_ZERO))
            mem[i] <= bus.wr_data[pick(hits(bus.wr_en, bus.wr_addr, ADDR_W'(i)))*DATA_W +: DATA_W];
   end
   generate
      for (p = 0; p < NUM_RD; p++) begin : g_rd
         logic [ADDR_W-1:0] a;
         logic [NUM_WR-1:0] h;
         assign a = bus.rd_addr[p*ADDR_W +: ADDR_W];
         assign h = hits(bus.wr_en, bus.wr_addr, a);
         assign bus.rd_data[p*DATA_W +: DATA_W] =
            (ZERO_REG != 0 && a == ADDR_W'(REG_ZERO)) ? '0 :
            (BYPASS != 0 && |h) ? bus.wr_data[pick(h)*DATA_W +: DATA_W] : mem[a];
         assign bus.rd_busy[p] = busy[a];
      end
   endgenerate
   regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
      .clk(clk),
      .rst(rst),
      .iss_en(bus.iss_en),
      .iss_addr(bus.iss_addr),
      .clr(clr),
      .busy(busy),
      .busy_cnt(bus.busy_cnt)
   );
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: directed plus random stimulus against an array/popcount model,
// driving a bypassing and a non-bypassing instance in lockstep.
module tb_multiport_register_file;
   import regfile_pkg::*;
   localparam int DW = 32, AW = 5, NR = 2, NW = 2, DEPTH = 32;
   logic clk = 0;
   logic rst;
   always #5 clk = ~clk;
   multiport_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();
   multiport_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) nb ();
   multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                             .ZERO_REG(1), .BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                             .ZERO_REG(1), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(nb.slave));
   assign nb.rd_addr  = bus.rd_addr;
   assign nb.wr_en    = bus.wr_en;
   assign nb.wr_addr  = bus.wr_addr;
   assign nb.wr_data  = bus.wr_data;
   assign nb.iss_en   = bus.iss_en;
   assign nb.iss_addr = bus.iss_addr;
   logic [DW-1:0] mem [DEPTH];
   bit busy [DEPTH];
   int n_chk = 0, n_pass = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   function automatic logic [DW-1:0] exp_rd(input int a, input bit byp);
      logic [DW-1:0] v;
      v = mem[a];
      if (byp)
         for (int w = 0; w < NW; w++)
            if (bus.wr_en[w] && int'(bus.wr_addr[w*AW +: AW]) == a) v = bus.wr_data[w*DW +: DW];
      return a == 0 ? '0 : v;
   endfunction
   function automatic int pop();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(busy[i]);
      return n;
   endfunction
   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = '0;
         busy[i] = 0;
      end
   endtask
   task automatic step();
      #1;
      for (int p = 0; p < NR; p++) begin
         int a;
         a = int'(bus.rd_addr[p*AW +: AW]);
         check($sformatf("rd%0d_a%0d", p, a), 64'(bus.rd_data[p*DW +: DW]), 64'(exp_rd(a, 1)));
         check($sformatf("nobyp_rd%0d_a%0d", p, a), 64'(nb.rd_data[p*DW +: DW]), 64'(exp_rd(a, 0)));
         check($sformatf("busy%0d_a%0d", p, a), 64'(bus.rd_busy[p]), 64'(busy[a]));
      end
      check("busy_cnt", 64'(bus.busy_cnt), 64'(pop()));
      check("nobyp_busy_cnt", 64'(nb.busy_cnt), 64'(pop()));
      @(posedge clk);
      if (rst) model_clear();
      else begin
         for (int w = 0; w < NW; w++)
            if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != 0)
               mem[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*DW +: DW];
         for (int w = 0; w < NW; w++)
            if (bus.wr_en[w]) busy[bus.wr_addr[w*AW +: AW]] = 0;
         if (bus.iss_en && bus.iss_addr != 0) busy[bus.iss_addr] = 1;
      end
      @(negedge clk);
   endtask
   task automatic idle();
      rst = 0;
      bus.wr_en = '0;
      bus.iss_en = 0;
   endtask
   task automatic wr(input int port, input int addr, input logic [DW-1:0] d);
      bus.wr_en[port] = 1;
      bus.wr_addr[port*AW +: AW] = AW'(addr);
      bus.wr_data[port*DW +: DW] = d;
   endtask
   task automatic rd(input int port, input int addr);
      bus.rd_addr[port*AW +: AW] = AW'(addr);
   endtask
   task automatic iss(input int addr);
      bus.iss_en = 1;
      bus.iss_addr = AW'(addr);
   endtask
   initial begin
      rst = 1;
      bus.wr_en = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.iss_en = 0;
      bus.iss_addr = '0;
      bus.rd_addr = '0;
      @(posedge clk);
      @(negedge clk);
      model_clear();
      idle();
      for (int a = 0; a < DEPTH; a += 2) begin
         rd(0, a);
         rd(1, a + 1);
         step();
      end
      wr(0, 1, 32'hA00000AA);
      step();
      idle();
      rd(1, 1);
      #1 check("basic_rd", 64'(bus.rd_data[DW +: DW]), 64'h A00000AA);
      step();
      wr(0, 0, 32'hFFFFFFFF);
      rd(0, 0);
      step();
      idle();
      #1 check("zero_rd", 64'(bus.rd_data[0 +: DW]), 64'h0);
      step();
      wr(0, 5, 32'h11);
      wr(1, 5, 32'h22);
      rd(0, 5);
      #1 check("conf_byp", 64'(bus.rd_data[0 +: DW]), 64'h22);
      check("conf_nobyp_old", 64'(nb.rd_data[0 +: DW]), 64'h0);
      step();
      idle();
      #1 check("conf_next", 64'(bus.rd_data[0 +: DW]), 64'h22);
      check("conf_next_nobyp", 64'(nb.rd_data[0 +: DW]), 64'h22);
      step();
      iss(8);
      rd(0, 8);
      step();
      idle();
      #1 check("sb_busy", 64'(bus.rd_busy[0]), 64'h1);
      check("sb_cnt1", 64'(bus.busy_cnt), 64'h1);
      wr(0, 8, 32'h88);
      step();
      idle();
      #1 check("sb_clr", 64'(bus.rd_busy[0]), 64'h0);
      check("sb_cnt0", 64'(bus.busy_cnt), 64'h0);
      iss(8);
      wr(1, 8, 32'h99);
      step();
      idle();
      #1 check("sb_iss_wins", 64'(bus.rd_busy[0]), 64'h1);
      wr(0, 8, 32'h9A);
      step();
      idle();
      iss(3); step();
      iss(4); step();
      iss(6); step();
      idle();
      #1 check("mc_cnt3", 64'(bus.busy_cnt), 64'h3);
      wr(0, 3, 32'h33);
      wr(1, 4, 32'h44);
      iss(7);
      step();
      idle();
      #1 check("mc_cnt2", 64'(bus.busy_cnt), 64'h2);
      wr(0, 9, 32'h1234);
      step();
      idle();
      rd(1, 9);
      step();
      rst = 1;
      wr(0, 9, 32'hDEAD);
      wr(1, 9, 32'hBEEF);
      iss(10);
      step();
      idle();
      #1 check("rst_reg9", 64'(bus.rd_data[DW +: DW]), 64'h0);
      check("rst_cnt", 64'(bus.busy_cnt), 64'h0);
      step();
      for (int c = 0; c < 400; c++) begin
         bit narrow;
         narrow = $urandom_range(0, 1) == 1;
         rst = $urandom_range(0, 49) == 0;
         for (int p = 0; p < NR; p++) rd(p, narrow ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
         bus.wr_en = '0;
         for (int w = 0; w < NW; w++)
            if ($urandom_range(0, 1) == 1)
               wr(w, narrow ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1), $urandom);
         bus.iss_en = $urandom_range(0, 2) != 0;
         bus.iss_addr = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
         step();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
